// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - ecode constants, exception bit indices, csr_op encodings, state type and MEM->WB bus layout
package wb_pkg;

   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_ADEF = 6'h08;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_SYS  = 6'h0B;
   localparam logic [5:0] ECODE_BRK  = 6'h0C;
   localparam logic [5:0] ECODE_INE  = 6'h0D;

   // exc field order on the bus is {ale, brk, sys, ine, adef}
   localparam int EXC_ADEF = 0;
   localparam int EXC_INE  = 1;
   localparam int EXC_SYS  = 2;
   localparam int EXC_BRK  = 3;
   localparam int EXC_ALE  = 4;

   localparam logic [1:0] CSR_OP_NONE = 2'b00;
   localparam logic [1:0] CSR_OP_RD   = 2'b01;
   localparam logic [1:0] CSR_OP_WR   = 2'b10;
   localparam logic [1:0] CSR_OP_XCHG = 2'b11;

   typedef enum logic {
      ST_RUN        = 1'b0,
      ST_FLUSH_WAIT = 1'b1
   } ws_state_e;

   localparam int MS_BUS_W = 188;
   localparam int RF_BUS_W = 38;

   localparam int OFF_PC         = 0;
   localparam int OFF_VADDR      = 32;
   localparam int OFF_RF_WDATA   = 64;
   localparam int OFF_RF_WADDR   = 96;
   localparam int OFF_RF_WE      = 101;
   localparam int OFF_CSR_WVALUE = 102;
   localparam int OFF_CSR_WMASK  = 134;
   localparam int OFF_CSR_NUM    = 166;
   localparam int OFF_CSR_OP     = 180;
   localparam int OFF_ERTN       = 182;
   localparam int OFF_EXC        = 183;

endpackage

// File: rtl/wb_exc_prio.sv
// rtl/wb_exc_prio.sv - fixed-priority exception cause selection for WB
module wb_exc_prio
   import wb_pkg::*;
(
   input  logic [4:0] exc,
   input  logic       has_int,
   output logic       any_cause,
   output logic [5:0] ecode,
   output logic [8:0] esubcode
);

   always_comb begin
      ecode = ECODE_INT;
      if (has_int)             ecode = ECODE_INT;
      else if (exc[EXC_ADEF])  ecode = ECODE_ADEF;
      else if (exc[EXC_INE])   ecode = ECODE_INE;
      else if (exc[EXC_SYS])   ecode = ECODE_SYS;
      else if (exc[EXC_BRK])   ecode = ECODE_BRK;
      else if (exc[EXC_ALE])   ecode = ECODE_ALE;
   end

   assign any_cause = has_int | (|exc);
   assign esubcode  = 9'd0;

endmodule

// File: rtl/wb_exc_commit.sv
// rtl/wb_exc_commit.sv - LoongArch WB stage: exception/ertn commit, CSR access, held front-end redirect; WB_EXC_COUNT_EN adds exc_cnt
module wb_exc_commit
   import wb_pkg::*;
#(
   parameter int INT_W = 13
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                ms_valid,
   input  logic [MS_BUS_W-1:0] ms_to_ws_bus,
   output logic                ws_allowin,
   input  logic                csr_crmd_ie,
   input  logic [INT_W-1:0]    csr_estat_is,
   input  logic [INT_W-1:0]    csr_ecfg_lie,
   input  logic [31:0]         csr_eentry,
   input  logic [31:0]         csr_era,
   input  logic [31:0]         csr_rvalue,
   output logic                csr_re,
   output logic [13:0]         csr_num,
   output logic                csr_we,
   output logic [31:0]         csr_wmask,
   output logic [31:0]         csr_wvalue,
   output logic                wb_ex,
   output logic [5:0]          wb_ecode,
   output logic [8:0]          wb_esubcode,
   output logic [31:0]         wb_pc,
   output logic [31:0]         wb_vaddr,
   output logic                ertn_flush,
   output logic [RF_BUS_W-1:0] ws_to_rf_bus,
   output logic                flush_valid,
   output logic [31:0]         flush_target,
   input  logic                flush_ack,
   output logic                ws_csr_block,
   output logic [31:0]         exc_cnt
);

   ws_state_e           state, state_nxt;
   logic                ws_valid;
   logic [MS_BUS_W-1:0] ws_bus;

   logic [4:0]  f_exc;
   logic        f_ertn;
   logic [1:0]  f_csr_op;
   logic [13:0] f_csr_num;
   logic [31:0] f_csr_wmask, f_csr_wvalue, f_rf_wdata, f_vaddr, f_pc;
   logic        f_rf_we;
   logic [4:0]  f_rf_waddr;

   assign f_exc        = ws_bus[OFF_EXC +: 5];
   assign f_ertn       = ws_bus[OFF_ERTN];
   assign f_csr_op     = ws_bus[OFF_CSR_OP +: 2];
   assign f_csr_num    = ws_bus[OFF_CSR_NUM +: 14];
   assign f_csr_wmask  = ws_bus[OFF_CSR_WMASK +: 32];
   assign f_csr_wvalue = ws_bus[OFF_CSR_WVALUE +: 32];
   assign f_rf_we      = ws_bus[OFF_RF_WE];
   assign f_rf_waddr   = ws_bus[OFF_RF_WADDR +: 5];
   assign f_rf_wdata   = ws_bus[OFF_RF_WDATA +: 32];
   assign f_vaddr      = ws_bus[OFF_VADDR +: 32];
   assign f_pc         = ws_bus[OFF_PC +: 32];

   logic       has_int, any_cause, commit_ertn, take_flush, csr_ok;
   logic [5:0] prio_ecode;
   logic [8:0] prio_esub;

   // ws_valid is only ever set in RUN, so gating by it also confines sampling to RUN
   assign has_int = ws_valid & csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));

   wb_exc_prio u_prio (
      .exc       (f_exc & {5{ws_valid}}),
      .has_int   (has_int),
      .any_cause (any_cause),
      .ecode     (prio_ecode),
      .esubcode  (prio_esub)
   );

   assign commit_ertn = ws_valid & f_ertn & ~any_cause;
   assign take_flush  = any_cause | commit_ertn;
   assign csr_ok      = ws_valid & ~any_cause;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:        if (take_flush) state_nxt = ST_FLUSH_WAIT;
         ST_FLUSH_WAIT: if (flush_ack)  state_nxt = ST_RUN;
         default:       state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_RUN;
      else       state <= state_nxt;
   end

   // an instruction arriving on the commit edge is younger than the flush and is killed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ws_valid <= 1'b0;
         ws_bus   <= '0;
      end else begin
         ws_valid <= (state == ST_RUN) & ms_valid & ~take_flush;
         if (ms_valid) ws_bus <= ms_to_ws_bus;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           flush_target <= 32'd0;
      else if (take_flush) flush_target <= any_cause ? csr_eentry : csr_era;
   end

   assign ws_allowin   = 1'b1;
   assign flush_valid  = (state == ST_FLUSH_WAIT);
   assign ws_csr_block = (ws_valid & (f_csr_op[1] | f_ertn | any_cause)) | (state == ST_FLUSH_WAIT);

   assign wb_ex       = any_cause;
   assign wb_ecode    = any_cause ? prio_ecode : 6'd0;
   assign wb_esubcode = any_cause ? prio_esub  : 9'd0;
   assign wb_pc       = ws_valid ? f_pc    : 32'd0;
   assign wb_vaddr    = ws_valid ? f_vaddr : 32'd0;
   assign ertn_flush  = commit_ertn;

   assign csr_num    = ws_valid ? f_csr_num : 14'd0;
   assign csr_re     = csr_ok & (f_csr_op != CSR_OP_NONE);
   assign csr_we     = csr_ok & f_csr_op[1];
   assign csr_wmask  = !csr_we ? 32'd0 : (f_csr_op == CSR_OP_WR) ? 32'hFFFF_FFFF : f_csr_wmask;
   assign csr_wvalue = csr_we ? f_csr_wvalue : 32'd0;

   assign ws_to_rf_bus = {csr_ok & f_rf_we,
                          ws_valid ? f_rf_waddr : 5'd0,
                          !ws_valid ? 32'd0 : (f_csr_op != CSR_OP_NONE) ? csr_rvalue : f_rf_wdata};

`ifdef WB_EXC_COUNT_EN
   logic [31:0] exc_cnt_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          exc_cnt_q <= 32'd0;
      else if (any_cause) exc_cnt_q <= exc_cnt_q + 32'd1;
   end
   assign exc_cnt = exc_cnt_q;
`else
   assign exc_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wb_exc_commit.sv
// tb/tb_wb_exc_commit.sv - self-checking bench for wb_exc_commit (honours WB_EXC_COUNT_EN)
`timescale 1ns/1ps
module tb_wb_exc_commit;

   localparam int INT_W = 13;

   logic              clk = 1'b0;
   logic              reset;
   logic              ms_valid;
   logic [187:0]      ms_to_ws_bus;
   logic              ws_allowin;
   logic              csr_crmd_ie;
   logic [INT_W-1:0]  csr_estat_is, csr_ecfg_lie;
   logic [31:0]       csr_eentry, csr_era, csr_rvalue;
   logic              csr_re, csr_we;
   logic [13:0]       csr_num;
   logic [31:0]       csr_wmask, csr_wvalue;
   logic              wb_ex;
   logic [5:0]        wb_ecode;
   logic [8:0]        wb_esubcode;
   logic [31:0]       wb_pc, wb_vaddr;
   logic              ertn_flush;
   logic [37:0]       ws_to_rf_bus;
   logic              flush_valid;
   logic [31:0]       flush_target;
   logic              flush_ack;
   logic              ws_csr_block;
   logic [31:0]       exc_cnt;

   always #5 clk = ~clk;

   wb_exc_commit #(.INT_W(INT_W)) dut (
      .clk(clk), .reset(reset), .ms_valid(ms_valid), .ms_to_ws_bus(ms_to_ws_bus),
      .ws_allowin(ws_allowin), .csr_crmd_ie(csr_crmd_ie), .csr_estat_is(csr_estat_is),
      .csr_ecfg_lie(csr_ecfg_lie), .csr_eentry(csr_eentry), .csr_era(csr_era),
      .csr_rvalue(csr_rvalue), .csr_re(csr_re), .csr_num(csr_num), .csr_we(csr_we),
      .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
      .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
      .ws_to_rf_bus(ws_to_rf_bus), .flush_valid(flush_valid), .flush_target(flush_target),
      .flush_ack(flush_ack), .ws_csr_block(ws_csr_block), .exc_cnt(exc_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [187:0] mk(input logic [4:0] exc, input logic ertn, input logic [1:0] op,
                                       input logic [13:0] num, input logic [31:0] wmask, input logic [31:0] wvalue,
                                       input logic rf_we, input logic [4:0] waddr, input logic [31:0] wdata,
                                       input logic [31:0] vaddr, input logic [31:0] pc);
      return {exc, ertn, op, num, wmask, wvalue, rf_we, waddr, wdata, vaddr, pc};
   endfunction

   // exc = {ale, brk, sys, ine, adef}; interrupt beats everything
   function automatic logic [5:0] cause_code(input logic irq, input logic [4:0] exc);
      if (irq)    return 6'h00;
      if (exc[0]) return 6'h08;
      if (exc[1]) return 6'h0D;
      if (exc[2]) return 6'h0B;
      if (exc[3]) return 6'h0C;
      if (exc[4]) return 6'h09;
      return 6'h00;
   endfunction

   // transaction-level model: the instruction in WB, whether a redirect is pending, and its target
   logic         m_have, m_flushing;
   logic [187:0] m_bus;
   logic [31:0]  m_target, m_cnt;

   logic [4:0]  m_exc;
   logic        m_ertn, m_rfwe;
   logic [1:0]  m_op;
   logic [13:0] m_num;
   logic [31:0] m_wmask, m_wvalue, m_wdata, m_vaddr, m_pc;
   logic [4:0]  m_waddr;
   logic        m_irq, m_cause, m_ertn_c, e_ok, e_csr_we;
   logic [31:0] e_wmask, e_cnt;
   logic [37:0] e_rf;

   assign {m_exc, m_ertn, m_op, m_num, m_wmask, m_wvalue, m_rfwe, m_waddr, m_wdata, m_vaddr, m_pc} = m_bus;
   assign m_irq    = csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
   assign m_cause  = m_have & (m_irq | (|m_exc));
   assign m_ertn_c = m_have & m_ertn & ~m_cause;
   assign e_ok     = m_have & ~m_cause;
   assign e_csr_we = e_ok & (m_op == 2'b10 || m_op == 2'b11);
   assign e_wmask  = !e_csr_we ? 32'd0 : (m_op == 2'b10) ? 32'hFFFF_FFFF : m_wmask;
   assign e_rf     = {e_ok & m_rfwe, m_have ? m_waddr : 5'd0,
                      !m_have ? 32'd0 : (m_op != 2'b00) ? csr_rvalue : m_wdata};
`ifdef WB_EXC_COUNT_EN
   assign e_cnt = m_cnt;
`else
   assign e_cnt = 32'd0;
`endif

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_have <= 1'b0; m_flushing <= 1'b0; m_bus <= '0; m_target <= 32'd0; m_cnt <= 32'd0;
      end else if (m_flushing) begin
         m_have <= 1'b0;
         if (flush_ack) m_flushing <= 1'b0;
      end else if (m_cause || m_ertn_c) begin
         m_flushing <= 1'b1;
         m_have     <= 1'b0;
         m_target   <= m_cause ? csr_eentry : csr_era;
         if (m_cause) m_cnt <= m_cnt + 32'd1;
      end else begin
         m_have <= ms_valid;
         m_bus  <= ms_to_ws_bus;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("ws_allowin",   64'(ws_allowin),   64'(1'b1));
         check("wb_ex",        64'(wb_ex),        64'(m_cause));
         check("wb_ecode",     64'(wb_ecode),     64'(m_cause ? cause_code(m_irq, m_exc) : 6'd0));
         check("wb_esubcode",  64'(wb_esubcode),  64'(9'd0));
         check("wb_pc",        64'(wb_pc),        64'(m_have ? m_pc : 32'd0));
         check("wb_vaddr",     64'(wb_vaddr),     64'(m_have ? m_vaddr : 32'd0));
         check("ertn_flush",   64'(ertn_flush),   64'(m_ertn_c));
         check("csr_re",       64'(csr_re),       64'(e_ok & (m_op != 2'b00)));
         check("csr_we",       64'(csr_we),       64'(e_csr_we));
         check("csr_num",      64'(csr_num),      64'(m_have ? m_num : 14'd0));
         check("csr_wmask",    64'(csr_wmask),    64'(e_wmask));
         check("csr_wvalue",   64'(csr_wvalue),   64'(e_csr_we ? m_wvalue : 32'd0));
         check("ws_to_rf_bus", 64'(ws_to_rf_bus), 64'(e_rf));
         check("flush_valid",  64'(flush_valid),  64'(m_flushing));
         check("flush_target", 64'(flush_target), 64'(m_target));
         check("ws_csr_block", 64'(ws_csr_block),
               64'((m_have & (m_op[1] | m_ertn | m_cause)) | m_flushing));
         check("exc_cnt",      64'(exc_cnt),      64'(e_cnt));
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [187:0] b);
      ms_valid = 1'b1; ms_to_ws_bus = b;
      step();
      ms_valid = 1'b0; ms_to_ws_bus = '0;
   endtask

   task automatic ack();
      flush_ack = 1'b1;
      step();
      flush_ack = 1'b0;
   endtask

   logic [4:0]  late_exc [3] = '{5'b00100, 5'b01000, 5'b00001};
   logic [5:0]  late_code[3] = '{6'h0B, 6'h0C, 6'h08};
   logic [31:0] cnt_exp;

   initial begin
      reset = 1'b1; ms_valid = 1'b0; ms_to_ws_bus = '0; csr_crmd_ie = 1'b0;
      csr_estat_is = '0; csr_ecfg_lie = '0; csr_eentry = 32'h1C00_8000; csr_era = 32'd0;
      csr_rvalue = 32'd0; flush_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_wb_ex",        64'(wb_ex),        64'(1'b0));
      check("rst_flush_valid",  64'(flush_valid),  64'(1'b0));
      check("rst_flush_target", 64'(flush_target), 64'(32'd0));
      check("rst_rf_bus",       64'(ws_to_rf_bus), 64'(38'd0));
      check("rst_exc_cnt",      64'(exc_cnt),      64'(32'd0));
      #1 reset = 1'b0;

      // csrwr returns the old value to the regfile
      csr_rvalue = 32'h0000_00A5;
      issue(mk(5'd0, 1'b0, 2'b10, 14'h030, 32'h0, 32'h1234_5678, 1'b1, 5'd4, 32'hDEAD, 32'h0, 32'h1C00_0000));
      check("t1_csr_we",    64'(csr_we),             64'(1'b1));
      check("t1_wmask",     64'(csr_wmask),          64'(32'hFFFF_FFFF));
      check("t1_wvalue",    64'(csr_wvalue),         64'(32'h1234_5678));
      check("t1_rf_wdata",  64'(ws_to_rf_bus[31:0]), 64'(32'hA5));
      check("t1_wb_ex",     64'(wb_ex),              64'(1'b0));

      // csrxchg uses the bus mask; a stray flush_ack in RUN must do nothing
      csr_rvalue = 32'h0000_0055; flush_ack = 1'b1;
      issue(mk(5'd0, 1'b0, 2'b11, 14'h031, 32'h0F0F, 32'hFFFF, 1'b1, 5'd5, 32'h0, 32'h0, 32'h1C00_0004));
      flush_ack = 1'b0;
      check("t1x_wmask",    64'(csr_wmask),   64'(32'h0F0F));
      check("t1x_flush",    64'(flush_valid), 64'(1'b0));
      issue(mk(5'd0, 1'b0, 2'b01, 14'h005, 32'h0, 32'h0, 1'b1, 5'd6, 32'h0, 32'h0, 32'h1C00_0008));
      step();

      // INE+BRK: INE wins; younger instruction during the wait is drained
      issue(mk(5'b01010, 1'b0, 2'b00, 14'h0, 32'h0, 32'h0, 1'b1, 5'd7, 32'h11, 32'h0, 32'h1C00_0100));
      check("t2_wb_ex",     64'(wb_ex),            64'(1'b1));
      check("t2_ecode",     64'(wb_ecode),         64'(6'h0D));
      check("t2_rf_we",     64'(ws_to_rf_bus[37]), 64'(1'b0));
      step();
      check("t2_flush_v",   64'(flush_valid),  64'(1'b1));
      check("t2_flush_t",   64'(flush_target), 64'(32'h1C00_8000));
      issue(mk(5'd0, 1'b0, 2'b00, 14'h0, 32'h0, 32'h0, 1'b1, 5'd8, 32'h22, 32'h0, 32'h1C00_0104));
      check("t2_drop_pc",   64'(wb_pc),        64'(32'd0));
      check("t2_drop_rf",   64'(ws_to_rf_bus), 64'(38'd0));
      ack();
      check("t2_acked",     64'(flush_valid),  64'(1'b0));

      // interrupt on a plain add
      csr_crmd_ie = 1'b1; csr_ecfg_lie = 13'h0800; csr_estat_is = 13'h0800;
      issue(mk(5'd0, 1'b0, 2'b00, 14'h0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h77, 32'h0, 32'h1C00_0200));
      check("t3_wb_ex",     64'(wb_ex),            64'(1'b1));
      check("t3_ecode",     64'(wb_ecode),         64'(6'h00));
      check("t3_pc",        64'(wb_pc),            64'(32'h1C00_0200));
      check("t3_rf_we",     64'(ws_to_rf_bus[37]), 64'(1'b0));
      step();
      csr_crmd_ie = 1'b0; csr_ecfg_lie = '0; csr_estat_is = '0;
      ack();

      // ertn redirects to era
      csr_era = 32'h1C00_0204;
      issue(mk(5'd0, 1'b1, 2'b00, 14'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h1C00_0300));
      check("t4_ertn",      64'(ertn_flush),   64'(1'b1));
      check("t4_wb_ex",     64'(wb_ex),        64'(1'b0));
      step();
      check("t4_ertn_1cyc", 64'(ertn_flush),   64'(1'b0));
      check("t4_flush_t",   64'(flush_target), 64'(32'h1C00_0204));
      check("t4_flush_v",   64'(flush_valid),  64'(1'b1));
      ack();

      // ALE beats ertn
      issue(mk(5'b10000, 1'b1, 2'b00, 14'h0, 32'h0, 32'h0, 1'b1, 5'd9, 32'h0, 32'h3, 32'h1C00_0400));
      check("t5_wb_ex",     64'(wb_ex),      64'(1'b1));
      check("t5_ecode",     64'(wb_ecode),   64'(6'h09));
      check("t5_vaddr",     64'(wb_vaddr),   64'(32'h3));
      check("t5_ertn",      64'(ertn_flush), 64'(1'b0));
      step();
      check("t5_flush_t",   64'(flush_target), 64'(32'h1C00_8000));
`ifdef WB_EXC_COUNT_EN
      cnt_exp = 32'd3;
`else
      cnt_exp = 32'd0;
`endif
      check("t5_exc_cnt",   64'(exc_cnt),      64'(cnt_exp));

      // reset while waiting for the ack
      reset = 1'b1; #1;
      check("t6_flush_v",   64'(flush_valid),  64'(1'b0));
      check("t6_flush_t",   64'(flush_target), 64'(32'd0));
      check("t6_exc_cnt",   64'(exc_cnt),      64'(32'd0));
      @(negedge clk); #1 reset = 1'b0;

      for (int i = 0; i < 3; i++) begin
         issue(mk(late_exc[i], 1'b0, 2'b00, 14'h0, 32'h0, 32'h0, 1'b1, 5'd1, 32'h0, 32'h0, 32'h1C00_0500 + 32'(i * 4)));
         check("t6_ecode", 64'(wb_ecode), 64'(late_code[i]));
         step();
         ack();
      end
      check("t6_exc_cnt3",  64'(exc_cnt), 64'(cnt_exp));

      step(); step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
